// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with frame-synchronous
// double-buffered value updates and optional leading-zero blanking.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   value, load   16-bit hex value and its 1-cycle capture strobe
//   digit_en      per-digit anode enable (0 forces that anode off)
//   dp_en         per-digit decimal point request (active-high)
//   hex           nibble of the scanned digit, to the segment decoder
//   an            anodes, active-low, at most one low
//   dp            decimal point, active-low
//   frame_tick    1-cycle pulse after the displayed value is reloaded
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_en,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;
  logic [1:0]    sel;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pending_valid;

  logic          tick;
  logic          boundary;
  logic          upd;
  logic [3:0]    nib;
  logic          blanked;
  logic          on;
  logic [3:0]    onehot;
  logic [3:0]    an_d;
  logic          dp_d;

  assign tick     = (count == CMAX);
  assign boundary = tick & (sel == 2'd3);
  // A load in the boundary cycle itself bypasses the pending buffer.
  assign upd      = boundary & (load | pending_valid);

  always_comb begin
    nib = 4'h0;
    unique case (sel)
      2'd0: nib = active[3:0];
      2'd1: nib = active[7:4];
      2'd2: nib = active[11:8];
      2'd3: nib = active[15:12];
    endcase
  end

  // Digit k>=1 is blank when it and every digit above it are zero.
  always_comb begin
    blanked = 1'b0;
    if (LZ_BLANK) begin
      unique case (sel)
        2'd0: blanked = 1'b0;
        2'd1: blanked = (active[15:4] == 12'h000);
        2'd2: blanked = (active[15:8] == 8'h00);
        2'd3: blanked = (active[15:12] == 4'h0);
      endcase
    end
  end

  always_comb begin
    on     = digit_en[sel] & ~blanked;
    onehot = 4'b0001 << sel;
    an_d   = ~(onehot & {4{on}});
    dp_d   = ~(dp_en[sel] & on);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      sel           <= 2'd0;
      active        <= 16'h0000;
      pending       <= 16'h0000;
      pending_valid <= 1'b0;
      frame_tick    <= 1'b0;
      an            <= 4'hF;
      dp            <= 1'b1;
      hex           <= 4'h0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) sel <= sel + 2'd1;

      if (upd) active <= load ? value : pending;
      if (load) pending <= value;

      if (upd)       pending_valid <= 1'b0;
      else if (load) pending_valid <= 1'b1;

      frame_tick <= upd;
      an         <= an_d;
      dp         <= dp_d;
      hex        <= nib;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4.
// Runs a plain and a leading-zero-blanking instance side by side.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_en = 4'h0;

  logic [3:0]  hex0, an0, hex1, an1;
  logic        dp0, ft0, dp1, ft1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Edges since reset release; state after edge c is
  // count=c%4, sel=(c/4)%4. Outputs lag by one edge.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .digit_en(digit_en), .dp_en(dp_en),
    .hex(hex0), .an(an0), .dp(dp0), .frame_tick(ft0)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .digit_en(digit_en), .dp_en(dp_en),
    .hex(hex1), .an(an1), .dp(dp1), .frame_tick(ft1)
  );

  function automatic logic [3:0] an_of(int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  function automatic logic [3:0] nib_of(logic [15:0] v, int s);
    return v[4*s +: 4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (cyc % 16 == 0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_frame: no frame start within 32 cycles, cyc=%0d", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an0 !== 4'hF || dp0 !== 1'b1 || hex0 !== 4'h0 || ft0 !== 1'b0) begin
        errors++;
        $display("FAIL reset: an=%b dp=%b hex=%h ft=%b want 1111 1 0 0",
                 an0, dp0, hex0, ft0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step();
      checks++;
      if (an0 !== an_of((i / 4) % 4) || ft0 !== 1'b0) begin
        errors++;
        $display("FAIL scan[%0d]: an=%b ft=%b want %b 0",
                 i, an0, ft0, an_of((i / 4) % 4));
      end
    end
  endtask

  task automatic test_load();
    wait_frame();
    value = 16'hA3C5;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame();
    checks++;
    if (ft0 !== 1'b1) begin
      errors++;
      $display("FAIL load_tick: ft=%b want 1", ft0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an0 !== an_of(i / 4) || hex0 !== nib_of(16'hA3C5, i / 4) ||
          dp0 !== 1'b1 || ft0 !== 1'b0) begin
        errors++;
        $display("FAIL load[%0d]: an=%b hex=%h dp=%b ft=%b want %b %h 1 0",
                 i, an0, hex0, dp0, ft0, an_of(i / 4),
                 nib_of(16'hA3C5, i / 4));
      end
    end
  endtask

  task automatic test_midframe();
    value = 16'h1234;
    load  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      load = 1'b0;
      checks++;
      if (hex0 !== nib_of(16'hA3C5, i / 4)) begin
        errors++;
        $display("FAIL hold_old[%0d]: hex=%h want %h",
                 i, hex0, nib_of(16'hA3C5, i / 4));
      end
    end
    checks++;
    if (ft0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_tick: ft=%b want 1", ft0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (hex0 !== nib_of(16'h1234, i / 4) || an0 !== an_of(i / 4)) begin
        errors++;
        $display("FAIL mid_new[%0d]: hex=%h an=%b want %h %b",
                 i, hex0, an0, nib_of(16'h1234, i / 4), an_of(i / 4));
      end
    end
    value = 16'h1111;
    load  = 1'b1;
    step();
    load  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    value = 16'h2222;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame();
    checks++;
    if (ft0 !== 1'b1) begin
      errors++;
      $display("FAIL two_tick: ft=%b want 1", ft0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (hex0 !== 4'h2) begin
        errors++;
        $display("FAIL two_loads[%0d]: hex=%h want 2", i, hex0);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++) step();
    value = 16'hBEEF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    checks++;
    if (cyc % 16 != 0 || ft0 !== 1'b1) begin
      errors++;
      $display("FAIL bypass_tick: cyc=%0d ft=%b want frame start and 1",
               cyc, ft0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (hex0 !== nib_of(16'hBEEF, i / 4) || an0 !== an_of(i / 4) ||
          ft0 !== 1'b0) begin
        errors++;
        $display("FAIL bypass[%0d]: hex=%h an=%b ft=%b want %h %b 0",
                 i, hex0, an0, ft0, nib_of(16'hBEEF, i / 4), an_of(i / 4));
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_a [4];
    logic [3:0] exp_z [4];
    exp_a = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_z = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    value = 16'h0070;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an1 !== exp_a[i / 4] || an0 !== an_of(i / 4) ||
          hex1 !== nib_of(16'h0070, i / 4)) begin
        errors++;
        $display("FAIL blank70[%0d]: an1=%b an0=%b hex1=%h want %b %b %h",
                 i, an1, an0, hex1, exp_a[i / 4], an_of(i / 4),
                 nib_of(16'h0070, i / 4));
      end
    end
    value = 16'h0000;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an1 !== exp_z[i / 4]) begin
        errors++;
        $display("FAIL blank0[%0d]: an1=%b want %b", i, an1, exp_z[i / 4]);
      end
    end
  endtask

  task automatic test_enables();
    logic [3:0] exp_a [4];
    logic       exp_d [4];
    exp_a = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
    digit_en = 4'b0101;
    dp_en    = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an0 !== exp_a[i / 4] || dp0 !== exp_d[i / 4]) begin
        errors++;
        $display("FAIL enables[%0d]: an=%b dp=%b want %b %b",
                 i, an0, dp0, exp_a[i / 4], exp_d[i / 4]);
      end
    end
    for (int i = 0; i < 9; i++) step();
    digit_en = 4'b1111;
    dp_en    = 4'b0000;
    reset    = 1'b1;
    step();
    checks++;
    if (an0 !== 4'hF || dp0 !== 1'b1 || hex0 !== 4'h0 || ft0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%b dp=%b hex=%h ft=%b want 1111 1 0 0",
               an0, dp0, hex0, ft0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (an0 !== an_of(i / 4) || hex0 !== 4'h0) begin
        errors++;
        $display("FAIL restart[%0d]: an=%b hex=%h want %b 0",
                 i, an0, hex0, an_of(i / 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_midframe();
    test_back_to_back();
    test_blank();
    test_enables();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
